// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin scheduler sharing one pipelined CORDIC among N
// requesters, with a tag delay line that steers each result back to the
// requester that issued it.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready[N]          per-requester handshake (ready is one-hot)
//   req_mode[N], req_x/y/z[N*W]     per-requester operands, requester i at [i*W +: W]
//   cord_en/mode/x/y/z              registered issue to the CORDIC core
//   cord_done, cord_xout/yout/zout  CORDIC result strobe and data
//   rsp_valid[N], rsp_x/y/z         one-hot result strobe + broadcast data (combinational)
//   err_mismatch                    sticky: cord_done disagreed with the tag line
module cordic_arbiter #(
  parameter int unsigned W       = 32,
  parameter int unsigned N       = 4,
  parameter int unsigned LAT     = 18,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N-1:0]   req_mode,
  input  logic [N*W-1:0] req_x,
  input  logic [N*W-1:0] req_y,
  input  logic [N*W-1:0] req_z,
  output logic           cord_en,
  output logic           cord_mode,
  output logic [W-1:0]   cord_x,
  output logic [W-1:0]   cord_y,
  output logic [W-1:0]   cord_z,
  input  logic           cord_done,
  input  logic [W-1:0]   cord_xout,
  input  logic [W-1:0]   cord_yout,
  input  logic [W-1:0]   cord_zout,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_x,
  output logic [W-1:0]   rsp_y,
  output logic [W-1:0]   rsp_z,
  output logic           err_mismatch
);

  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW  = $clog2(MAX_OUT + 1);

  logic [CW-1:0]  out_cnt [N];
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] issue_id;
  logic [IDW-1:0] gnt_id;
  logic [N-1:0]   elig;
  logic [N-1:0]   grant;
  logic           gnt_any;
  int unsigned    idx;
  logic           sel_mode;
  logic [W-1:0]   sel_x, sel_y, sel_z;
  logic [LAT:0]   tag_v;
  logic [IDW-1:0] tag_id [LAT+1];
  logic           tag_hit;

  // Tag entry LAT lines up with cord_done: stage 0 loads when the core samples
  // cord_en, and the core reports done LAT clocks after that sample.
  assign tag_hit = cord_done & tag_v[LAT];

  // Result steering; a mismatch (done without a tag, or tag without done) yields nothing.
  always_comb begin
    rsp_valid = '0;
    if (tag_hit) rsp_valid[tag_id[LAT]] = 1'b1;
  end

  assign rsp_x = cord_xout;
  assign rsp_y = cord_yout;
  assign rsp_z = cord_zout;

  // Eligibility credits a same-cycle return so a full requester can be re-granted at once.
  always_comb begin
    elig = '0;
    for (int i = 0; i < int'(N); i++) begin
      elig[i] = req_valid[i] && ((out_cnt[i] - CW'(rsp_valid[i])) < CW'(MAX_OUT));
    end
  end

  // Round-robin search starting at rr_ptr; nothing is granted while in reset.
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(rr_ptr) + off) % N;
      if (!gnt_any && elig[IDW'(idx)]) begin
        gnt_any            = 1'b1;
        gnt_id             = IDW'(idx);
        grant[IDW'(idx)]   = 1'b1;
      end
    end
    if (!rst_n) begin
      grant   = '0;
      gnt_any = 1'b0;
    end
  end

  assign req_ready = grant;

  // Operand mux for the granted requester.
  always_comb begin
    sel_mode = 1'b0;
    sel_x    = '0;
    sel_y    = '0;
    sel_z    = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant[i]) begin
        sel_mode = req_mode[i];
        sel_x    = req_x[i*W +: W];
        sel_y    = req_y[i*W +: W];
        sel_z    = req_z[i*W +: W];
      end
    end
  end

  // Issue registers and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cord_en   <= 1'b0;
      cord_mode <= 1'b0;
      cord_x    <= '0;
      cord_y    <= '0;
      cord_z    <= '0;
      issue_id  <= '0;
      rr_ptr    <= '0;
    end else begin
      cord_en <= gnt_any;
      if (gnt_any) begin
        cord_mode <= sel_mode;
        cord_x    <= sel_x;
        cord_y    <= sel_y;
        cord_z    <= sel_z;
        issue_id  <= gnt_id;
        rr_ptr    <= IDW'((32'(gnt_id) + 32'd1) % N);
      end
    end
  end

  // Tag delay line tracking which requester owns each in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int i = 0; i <= int'(LAT); i++) tag_id[i] <= '0;
    end else begin
      tag_v     <= {tag_v[LAT-1:0], cord_en};
      tag_id[0] <= issue_id;
      for (int i = 1; i <= int'(LAT); i++) tag_id[i] <= tag_id[i-1];
    end
  end

  // Per-requester outstanding counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N); i++) out_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        case ({grant[i], rsp_valid[i]})
          2'b10:   out_cnt[i] <= out_cnt[i] + CW'(1);
          2'b01:   out_cnt[i] <= out_cnt[i] - CW'(1);
          default: out_cnt[i] <= out_cnt[i];
        endcase
      end
    end
  end

  // Sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_mismatch <= 1'b0;
    else if (cord_done != tag_v[LAT]) err_mismatch <= 1'b1;
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter. A behavioural stand-in for the CORDIC
// returns (x+1, y+2, z+3) LAT clocks after it samples cord_en, so result
// routing and timing can be checked exactly.
module tb_cordic_arbiter;

  localparam int unsigned W       = 32;
  localparam int unsigned N       = 4;
  localparam int unsigned LAT     = 18;
  localparam int unsigned MAX_OUT = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_mode;
  logic [N*W-1:0] req_x, req_y, req_z;
  logic           cord_en, cord_mode;
  logic [W-1:0]   cord_x, cord_y, cord_z;
  logic           cord_done;
  logic [W-1:0]   cord_xout, cord_yout, cord_zout;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_x, rsp_y, rsp_z;
  logic           err_mismatch;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cordic_arbiter #(.W(W), .N(N), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .cord_en(cord_en), .cord_mode(cord_mode),
    .cord_x(cord_x), .cord_y(cord_y), .cord_z(cord_z),
    .cord_done(cord_done),
    .cord_xout(cord_xout), .cord_yout(cord_yout), .cord_zout(cord_zout),
    .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
    .err_mismatch(err_mismatch)
  );

  // Stand-in CORDIC: done appears LAT clocks after the edge that samples en.
  logic [LAT:0] core_v;
  logic [W-1:0] core_x [LAT+1];
  logic [W-1:0] core_y [LAT+1];
  logic [W-1:0] core_z [LAT+1];
  logic         force_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_v <= '0;
      for (int i = 0; i <= int'(LAT); i++) begin
        core_x[i] <= '0; core_y[i] <= '0; core_z[i] <= '0;
      end
    end else begin
      core_v    <= {core_v[LAT-1:0], cord_en};
      core_x[0] <= cord_x + 32'd1;
      core_y[0] <= cord_y + 32'd2;
      core_z[0] <= cord_z + 32'd3;
      for (int i = 1; i <= int'(LAT); i++) begin
        core_x[i] <= core_x[i-1]; core_y[i] <= core_y[i-1]; core_z[i] <= core_z[i-1];
      end
    end
  end

  assign cord_done = core_v[LAT] | force_done;
  assign cord_xout = core_x[LAT];
  assign cord_yout = core_y[LAT];
  assign cord_zout = core_z[LAT];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    req_valid = 4'hF;
    rst_n     = 1'b0;
    #3;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
    end
    checks++;
    if (cord_en !== 1'b0 || cord_mode !== 1'b0 || cord_x !== '0 || cord_y !== '0 || cord_z !== '0) begin
      errors++; $display("FAIL reset_issue: got en=%b mode=%b x=%h y=%h z=%h expected all 0",
                         cord_en, cord_mode, cord_x, cord_y, cord_z);
    end
    checks++;
    if (err_mismatch !== 1'b0 || rsp_valid !== 4'b0000 || rsp_x !== '0) begin
      errors++; $display("FAIL reset_rsp: got err=%b rsp_valid=%b rsp_x=%h expected 0",
                         err_mismatch, rsp_valid, rsp_x);
    end
    tick();
    tick();
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready_held: got %b expected 0000", req_ready);
    end
    req_valid = '0;
    rst_n     = 1'b1;
    #1;
  endtask

  task automatic test_single();
    int       hit_at;
    int       hits;
    logic [N-1:0] got_v;
    logic [W-1:0] gx, gy, gz;
    hit_at = -1; hits = 0; got_v = '0; gx = '0; gy = '0; gz = '0;
    req_x[2*W +: W] = 32'h0001_0000;
    req_y[2*W +: W] = 32'h0000_0000;
    req_z[2*W +: W] = 32'h002D_0000;
    req_mode  = 4'b0100;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_grant: got %b expected 0100", req_ready);
    end
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (cord_en !== 1'b1 || cord_mode !== 1'b1 || cord_x !== 32'h0001_0000 || cord_z !== 32'h002D_0000) begin
      errors++; $display("FAIL single_issue: got en=%b mode=%b x=%h z=%h expected 1 1 00010000 002d0000",
                         cord_en, cord_mode, cord_x, cord_z);
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL single_ready_drop: got %b expected 0000", req_ready);
    end
    for (int n = 1; n <= 25; n++) begin
      tick();
      if (rsp_valid !== 4'b0000) begin
        hits++;
        if (hit_at < 0) begin
          hit_at = n; got_v = rsp_valid; gx = rsp_x; gy = rsp_y; gz = rsp_z;
        end
      end
    end
    checks++;
    if (hit_at != 19 || hits != 1) begin
      errors++; $display("FAIL single_latency: got cycle %0d (%0d pulses) expected cycle 19 (1 pulse)", hit_at, hits);
    end
    checks++;
    if (got_v !== 4'b0100) begin
      errors++; $display("FAIL single_rsp_valid: got %b expected 0100", got_v);
    end
    checks++;
    if (gx !== 32'h0001_0001 || gy !== 32'h0000_0002 || gz !== 32'h002D_0003) begin
      errors++; $display("FAIL single_rsp_data: got %h %h %h expected 00010001 00000002 002d0003", gx, gy, gz);
    end
    checks++;
    if (err_mismatch !== 1'b0) begin
      errors++; $display("FAIL single_err: got %b expected 0", err_mismatch);
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_v;
    logic [W-1:0] exp_x;
    int           k;
    for (int i = 0; i < int'(N); i++) begin
      req_x[i*W +: W] = 32'(32'h100 * (i + 1));
      req_y[i*W +: W] = 32'(i);
      req_z[i*W +: W] = '0;
    end
    req_mode  = 4'hF;
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_v = 4'b0001 << (c % 4);
      checks++;
      if (req_ready !== exp_v) begin
        errors++; $display("FAIL fair_grant[%0d]: got %b expected %b", c, req_ready, exp_v);
      end
      tick();
    end
    req_valid = '0;
    for (int t = 8; t <= 30; t++) begin
      tick();
      if (t >= 19 && t <= 26) begin
        k     = (t - 19) % 4;
        exp_v = 4'b0001 << k;
        exp_x = 32'(32'h100 * (k + 1) + 1);
      end else begin
        exp_v = '0;
        exp_x = rsp_x;
      end
      checks++;
      if (rsp_valid !== exp_v || rsp_x !== exp_x) begin
        errors++; $display("FAIL fair_rsp[%0d]: got %b x=%h expected %b x=%h", t, rsp_valid, rsp_x, exp_v, exp_x);
      end
    end
  endtask

  task automatic test_outstanding();
    logic exp_r, exp_s;
    req_x[0 +: W] = 32'h55;
    req_mode      = 4'b0001;
    req_valid     = 4'b0001;
    for (int t = 0; t < 45; t++) begin
      #1;
      exp_r = (t % 20) < 4;
      exp_s = (t >= 20) && ((t % 20) < 4);
      checks++;
      if (req_ready !== {3'b000, exp_r} || rsp_valid !== {3'b000, exp_s}) begin
        errors++; $display("FAIL outstanding[%0d]: got ready=%b rsp=%b expected ready=%b rsp=%b",
                           t, req_ready, rsp_valid, {3'b000, exp_r}, {3'b000, exp_s});
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_mismatch();
    force_done = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 4'b0000 || err_mismatch !== 1'b0) begin
      errors++; $display("FAIL mismatch_same_cycle: got rsp=%b err=%b expected 0000 0", rsp_valid, err_mismatch);
    end
    tick();
    force_done = 1'b0;
    #1;
    checks++;
    if (err_mismatch !== 1'b1) begin
      errors++; $display("FAIL mismatch_set: got %b expected 1", err_mismatch);
    end
    tick(); tick(); tick();
    checks++;
    if (err_mismatch !== 1'b1) begin
      errors++; $display("FAIL mismatch_sticky: got %b expected 1", err_mismatch);
    end
    // Counters must be untouched: exactly MAX_OUT grants, then none.
    req_mode  = 4'b0001;
    req_valid = 4'b0001;
    for (int t = 0; t < 6; t++) begin
      #1;
      checks++;
      if (req_ready !== ((t < 4) ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL mismatch_credit[%0d]: got %b expected %b", t, req_ready,
                           (t < 4) ? 4'b0001 : 4'b0000);
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_reset_midflight();
    int bad;
    int hit_at;
    bad = 0; hit_at = -1;
    req_mode  = 4'b0111;
    req_valid = 4'b0111;
    tick(); tick(); tick();
    req_valid = '0;
    tick(); tick();
    rst_n     = 1'b0;
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0000 || cord_en !== 1'b0 || cord_x !== '0 || rsp_valid !== 4'b0000 || err_mismatch !== 1'b0) begin
      errors++; $display("FAIL midflight_reset_vals: got ready=%b en=%b x=%h rsp=%b err=%b expected all 0",
                         req_ready, cord_en, cord_x, rsp_valid, err_mismatch);
    end
    req_valid = '0;
    tick(); tick();
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (rsp_valid !== 4'b0000 || err_mismatch !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL midflight_quiet: got %0d cycles with rsp/err expected 0", bad);
    end
    req_x[1*W +: W] = 32'h1234;
    req_valid       = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL midflight_regrant: got %b expected 0010", req_ready);
    end
    tick();
    req_valid = '0;
    for (int n = 1; n <= 25; n++) begin
      tick();
      if (rsp_valid !== 4'b0000 && hit_at < 0) hit_at = n;
    end
    checks++;
    if (hit_at != 19) begin
      errors++; $display("FAIL midflight_fresh_latency: got cycle %0d expected 19", hit_at);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_mode = '0;
    req_x = '0; req_y = '0; req_z = '0; force_done = 1'b0;
    test_reset();
    test_single();
    test_reset();
    test_fairness();
    test_reset();
    test_outstanding();
    test_reset();
    test_mismatch();
    test_reset();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
